// File: rtl/gate_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// gate_truth_table_scanner
//
// Purpose:
//   N-input configurable logic gate (AND/OR/NAND/NOR/XOR/XNOR) with a built-in
//   sweep engine. A start pulse in IDLE latches the gate mode, then the engine
//   applies every input vector 0..2^N-1 (one per clock) to the gate and
//   captures each result into a 2^N-bit truth-table register.
//
// Parameters:
//   N           number of gate inputs, legal range 1..6 (table <= 64 bits)
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   start       scan request, sampled only in IDLE
//   mode[2:0]   gate select: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR,
//               101 XNOR; 110/111 illegal (rejected with a mode_err pulse)
//   busy        high while the sweep is running
//   done        one-cycle pulse when table_out is complete
//   mode_err    one-cycle pulse when start arrives with an illegal mode
//   vec_out     input vector currently applied to the gate (0 when idle)
//   y_out       gate output for vec_out under the latched mode (0 when idle)
//   table_out   captured truth table; bit i = gate result for vector i
//   ones_count  number of ones in the table (only with GATE_SCAN_POPCOUNT_EN)
//
// Optional feature:
//   GATE_SCAN_POPCOUNT_EN  adds the ones_count output and its counter.
// -----------------------------------------------------------------------------
module gate_truth_table_scanner #(
  parameter int N = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         mode,
  output logic               busy,
  output logic               done,
  output logic               mode_err,
  output logic [N-1:0]       vec_out,
  output logic               y_out,
  output logic [(1<<N)-1:0]  table_out
`ifdef GATE_SCAN_POPCOUNT_EN
  ,
  output logic [N:0]         ones_count
`endif
);

  localparam int T = 1 << N;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only the six defined gate codes start a scan.
  function automatic logic mode_legal(input logic [2:0] m);
    logic ok;
    case (m)
      3'b000, 3'b001, 3'b010,
      3'b011, 3'b100, 3'b101: ok = 1'b1;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Gate function over the whole vector; reduction operators make N=1 a buffer
  // for AND/OR/XOR automatically.
  function automatic logic gate_eval(input logic [2:0] m, input logic [N-1:0] v);
    logic g;
    case (m)
      3'b000:  g = &v;
      3'b001:  g = |v;
      3'b010:  g = ~(&v);
      3'b011:  g = ~(|v);
      3'b100:  g = ^v;
      3'b101:  g = ~(^v);
      default: g = 1'b0;
    endcase
    return g;
  endfunction

  state_t          state_q;
  logic [N-1:0]    idx_q;
  logic [N-1:0]    idx_d;
  logic [2:0]      mode_q;
  logic [T-1:0]    table_q;
  logic            busy_q;
  logic            done_q;
  logic            mode_err_q;
  logic            y_s;
`ifdef GATE_SCAN_POPCOUNT_EN
  logic [N:0]      ones_q;
`endif

  assign idx_d = idx_q + {{(N-1){1'b0}}, 1'b1};

  // Gate output: driven only while scanning so idle outputs read zero even
  // for the inverting modes.
  always_comb begin
    y_s = 1'b0;
    if (busy_q) begin
      y_s = gate_eval(mode_q, idx_q);
    end else begin
      y_s = 1'b0;
    end
  end

  // Sweep FSM with its registered outputs; idx_q is kept at zero outside the
  // sweep so it can drive vec_out directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= {N{1'b0}};
      mode_q     <= 3'b000;
      table_q    <= {T{1'b0}};
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
`ifdef GATE_SCAN_POPCOUNT_EN
      ones_q     <= {(N+1){1'b0}};
`endif
    end else begin
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (mode_legal(mode)) begin
              mode_q  <= mode;
              idx_q   <= {N{1'b0}};
              table_q <= {T{1'b0}};
              busy_q  <= 1'b1;
              state_q <= ST_SCAN;
`ifdef GATE_SCAN_POPCOUNT_EN
              ones_q  <= {(N+1){1'b0}};
`endif
            end else begin
              mode_err_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          table_q[idx_q] <= y_s;
`ifdef GATE_SCAN_POPCOUNT_EN
          if (y_s) begin
            ones_q <= ones_q + {{N{1'b0}}, 1'b1};
          end
`endif
          // Last vector reached: finish instead of wrapping the counter.
          if (&idx_q) begin
            idx_q   <= {N{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= {N{1'b0}};
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mode_err  = mode_err_q;
  assign vec_out   = idx_q;
  assign y_out     = y_s;
  assign table_out = table_q;
`ifdef GATE_SCAN_POPCOUNT_EN
  assign ones_count = ones_q;
`endif

endmodule

// File: tb/tb_gate_truth_table_scanner.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_table_scanner
//
// Scoreboard bench for gate_truth_table_scanner with N=3. The driver pushes
// the latched mode of every accepted scan into a queue; a negedge monitor
// compares each scan cycle, the done pulse and idle outputs against a model
// that derives gate results from the number of ones in each input vector.
// -----------------------------------------------------------------------------
module tb_gate_truth_table_scanner;

  localparam int N = 3;
  localparam int T = 1 << N;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    mode;
  logic          busy;
  logic          done;
  logic          mode_err;
  logic [N-1:0]  vec_out;
  logic          y_out;
  logic [T-1:0]  table_out;
`ifdef GATE_SCAN_POPCOUNT_EN
  logic [N:0]    ones_count;
  int            last_ones = 0;
`endif

  gate_truth_table_scanner #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .busy      (busy),
    .done      (done),
    .mode_err  (mode_err),
    .vec_out   (vec_out),
    .y_out     (y_out),
    .table_out (table_out)
`ifdef GATE_SCAN_POPCOUNT_EN
    ,
    .ones_count(ones_count)
`endif
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           exp_q[$];
  int           err_pend = 0;
  int           vec_cnt = 0;
  logic [T-1:0] last_tbl = '0;
  bit           mon_en = 1'b0;

  // Reference gate: decided purely by how many inputs are high.
  function automatic logic ref_y(int m, int v);
    int c;
    c = $countones(v);
    case (m)
      0: return (c == N);
      1: return (c > 0);
      2: return (c != N);
      3: return (c == 0);
      4: return (c % 2 == 1);
      5: return (c % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [T-1:0] ref_table(int m);
    logic [T-1:0] t;
    t = '0;
    for (int i = 0; i < T; i++) t[i] = ref_y(m, i);
    return t;
  endfunction

  function automatic int ref_ones(int m);
    int c;
    c = 0;
    for (int i = 0; i < T; i++) c += int'(ref_y(m, i));
    return c;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: checks every cycle against the queued request.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mode_err) begin
        chk("mode_err_expected", (err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
      end
      if (done) begin
        chk("done_pending", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          int m;
          m = exp_q.pop_front();
          chk("done_table", table_out, ref_table(m));
          chk("scan_len", vec_cnt, T);
          chk("busy_at_done", busy, 0);
          last_tbl = ref_table(m);
`ifdef GATE_SCAN_POPCOUNT_EN
          chk("ones_at_done", ones_count, ref_ones(m));
          last_ones = ref_ones(m);
`endif
        end
      end
      if (busy) begin
        chk("busy_has_req", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          int m;
          logic [T-1:0] p;
          m = exp_q[0];
          p = '0;
          for (int i = 0; i < vec_cnt && i < T; i++) p[i] = ref_y(m, i);
          chk("scan_vec", vec_out, vec_cnt);
          chk("scan_y", y_out, ref_y(m, vec_cnt));
          chk("scan_partial_table", table_out, p);
        end
        vec_cnt++;
      end else begin
        vec_cnt = 0;
        chk("idle_vec", vec_out, 0);
        chk("idle_y", y_out, 0);
        if (!done) begin
          chk("idle_table_hold", table_out, last_tbl);
`ifdef GATE_SCAN_POPCOUNT_EN
          chk("idle_ones_hold", ones_count, last_ones);
`endif
        end
      end
    end
  end

  task automatic start_scan(int m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 3'(m);
    exp_q.push_back(m);
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (n < T + 10) begin
      @(negedge clk);
      if (done) break;
      n++;
    end
    chk("done_seen", done, 1);
    if (!done) exp_q.delete();
  endtask

  task automatic scan(int m);
    start_scan(m);
    wait_done();
  endtask

  task automatic illegal(int m);
    @(posedge clk); #1;
    start = 1'b1;
    mode  = 3'(m);
    err_pend++;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("illegal_busy", busy, 0);
    chk("illegal_err_pulse", mode_err, 1);
    @(negedge clk);
    chk("illegal_err_one_cycle", mode_err, 0);
  endtask

  task automatic clear_after_reset();
    last_tbl = '0;
`ifdef GATE_SCAN_POPCOUNT_EN
    last_ones = 0;
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 3'b000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mode_err", mode_err, 0);
    chk("rst_vec", vec_out, 0);
    chk("rst_y", y_out, 0);
    chk("rst_table", table_out, 0);
    mon_en = 1'b1;

    // Every gate, back to back.
    for (int m = 0; m < 6; m++) scan(m);

    // Illegal codes leave state and table alone.
    illegal(6);
    illegal(7);

    // start and mode changes inside a scan must be ignored.
    start_scan(0);
    @(posedge clk); #1;
    start = 1'b1; mode = 3'b001;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Reset in the middle of an XOR scan drops it without a done pulse.
    start_scan(4);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    clear_after_reset();
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_table", table_out, 0);
    chk("midrst_vec", vec_out, 0);
    repeat (T + 2) @(posedge clk);
    scan(4);

    // Reset wins over a simultaneous start.
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; mode = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    clear_after_reset();
    @(negedge clk);
    chk("rst_vs_start_busy", busy, 0);
    repeat (3) @(posedge clk);

    // Random mix of legal and illegal requests.
    repeat (30) begin
      int r;
      r = $urandom_range(0, 7);
      if (r < 6) scan(r);
      else illegal(r);
    end

    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    chk("errs_drained", err_pend, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
